reorder_retire_buff: RTL and testbench

- In-order allocate / out-of-order complete / in-order retire buffer at the output of a multi-stage pipeline with skipping.
- Each issuing operation takes a tag, the slot index of the next free entry.
- Pipeline stages write results back by tag in any order.
- Results drain to the downstream consumer strictly in allocation order, under a valid/nack handshake.

---
 rtl/reorder_retire_buff_pkg.sv | 19 +
 rtl/reorder_retire_buff_ptr_ctrl.sv | 62 ++++++
 rtl/reorder_retire_buff.sv | 115 +++++++++++
 tb/tb_reorder_retire_buff.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_retire_buff_pkg.sv
// Shared types and helpers for the reorder/retire buffer.
package reorder_retire_buff_pkg;

  // Wide carrier for pointer arithmetic so one helper serves every tag width.
  localparam int PTR_MAX_W = 16;
  typedef logic [PTR_MAX_W-1:0] ptr_wide_t;

  // Per-slot status: alloc = slot owned by an in-flight op, done = result written.
  typedef struct packed {
    logic alloc;
    logic done;
  } slot_stat_t;

  // Explicit wrap so non-power-of-two slot counts advance correctly.
  function automatic ptr_wide_t ptr_wrap_inc(input ptr_wide_t ptr, input ptr_wide_t last);
    return (ptr == last) ? '0 : ptr + 1'b1;
  endfunction

endpackage

// File: rtl/reorder_retire_buff_ptr_ctrl.sv
// Alloc/head pointers and occupancy count for the reorder/retire buffer.
module reorder_ptr_ctrl
  import reorder_retire_buff_pkg::*;
#(
  parameter int NUM_ENTRY = 4,
  parameter int WIDTH_TAG = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clr_i,
  input  logic                 alloc_inc_i,
  input  logic                 head_inc_i,
  output logic [WIDTH_TAG-1:0] aptr_o,
  output logic [WIDTH_TAG-1:0] hptr_o,
  output logic                 full_o,
  output logic                 empty_o
);

  typedef logic [WIDTH_TAG-1:0] tag_t;
  typedef logic [WIDTH_TAG:0]   cnt_t;

  localparam ptr_wide_t LAST     = ptr_wide_t'(NUM_ENTRY - 1);
  localparam cnt_t      CNT_FULL = cnt_t'(NUM_ENTRY);

  tag_t aptr_q, aptr_d;
  tag_t hptr_q, hptr_d;
  cnt_t cnt_q, cnt_d;

  // Next pointer/count values; simultaneous alloc and retire keep the count.
  always_comb begin
    aptr_d = aptr_q;
    hptr_d = hptr_q;
    cnt_d  = cnt_q;
    if (alloc_inc_i) aptr_d = tag_t'(ptr_wrap_inc(ptr_wide_t'(aptr_q), LAST));
    if (head_inc_i)  hptr_d = tag_t'(ptr_wrap_inc(ptr_wide_t'(hptr_q), LAST));
    if (alloc_inc_i && !head_inc_i)      cnt_d = cnt_q + 1'b1;
    else if (!alloc_inc_i && head_inc_i) cnt_d = cnt_q - 1'b1;
  end

  // Pointer/count registers; clear wins over any same-cycle strobe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      aptr_q <= '0;
      hptr_q <= '0;
      cnt_q  <= '0;
    end else if (clr_i) begin
      aptr_q <= '0;
      hptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      aptr_q <= aptr_d;
      hptr_q <= hptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign aptr_o  = aptr_q;
  assign hptr_o  = hptr_q;
  assign full_o  = (cnt_q == CNT_FULL);
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/reorder_retire_buff.sv
// In-order allocate / out-of-order complete / in-order retire buffer.
// Handshake: O_Valid is raised whenever the head slot holds a result; the
// result leaves on any cycle where O_Valid=1 and I_Nack=0, otherwise
// O_Valid and O_Data hold.
module reorder_retire_buff
  import reorder_retire_buff_pkg::*;
#(
  parameter  int NUM_ENTRY  = 4,
  parameter  int WIDTH_DATA = 32,
  localparam int WIDTH_TAG  = $clog2(NUM_ENTRY)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  I_Clr,
  input  logic                  I_Alloc,
  output logic                  O_Alloc_Ack,
  output logic [WIDTH_TAG-1:0]  O_Tag,
  input  logic                  I_Cmp_We,
  input  logic [WIDTH_TAG-1:0]  I_Cmp_Tag,
  input  logic [WIDTH_DATA-1:0] I_Cmp_Data,
  output logic                  O_Valid,
  output logic [WIDTH_DATA-1:0] O_Data,
  input  logic                  I_Nack,
  output logic                  O_Full,
  output logic                  O_Empty,
  output logic                  O_Err
);

  typedef logic [WIDTH_TAG-1:0] tag_t;

  slot_stat_t            stat_q [NUM_ENTRY];
  slot_stat_t            stat_d [NUM_ENTRY];
  logic [WIDTH_DATA-1:0] data_q [NUM_ENTRY];

  tag_t       aptr, hptr;
  logic       full, empty;
  logic       ack, retire, cmp_ok;
  slot_stat_t cmp_stat;
  logic       err_q, err_d;

  reorder_ptr_ctrl #(
    .NUM_ENTRY (NUM_ENTRY),
    .WIDTH_TAG (WIDTH_TAG)
  ) u_ptr (
    .clock       (clock),
    .reset       (reset),
    .clr_i       (I_Clr),
    .alloc_inc_i (ack),
    .head_inc_i  (retire),
    .aptr_o      (aptr),
    .hptr_o      (hptr),
    .full_o      (full),
    .empty_o     (empty)
  );

  // No bypass from a same-cycle retire: a full buffer refuses allocation.
  assign ack         = I_Alloc & ~full;
  assign O_Alloc_Ack = ack;
  assign O_Tag       = aptr;
  assign O_Full      = full;
  assign O_Empty     = empty;
  assign O_Valid     = stat_q[hptr].alloc & stat_q[hptr].done;
  assign O_Data      = data_q[hptr];
  assign retire      = O_Valid & ~I_Nack;
  assign O_Err       = err_q;

  // Look up the completion target; tags past the last slot read as unallocated.
  always_comb begin
    cmp_stat = '0;
    for (int i = 0; i < NUM_ENTRY; i++) begin
      if (I_Cmp_Tag == tag_t'(i)) cmp_stat = stat_q[i];
    end
  end

  // A completion is legal only into an allocated, not-yet-done slot.
  assign cmp_ok = I_Cmp_We & cmp_stat.alloc & ~cmp_stat.done;
  assign err_d  = err_q | (I_Cmp_We & ~cmp_ok);

  // Slot status next-state; alloc, retire and completion always hit distinct slots.
  always_comb begin
    for (int i = 0; i < NUM_ENTRY; i++) begin
      stat_d[i] = stat_q[i];
      if (ack && aptr == tag_t'(i)) begin
        stat_d[i].alloc = 1'b1;
        stat_d[i].done  = 1'b0;
      end else if (retire && hptr == tag_t'(i)) begin
        stat_d[i] = '0;
      end else if (cmp_ok && I_Cmp_Tag == tag_t'(i)) begin
        stat_d[i].done = 1'b1;
      end
    end
  end

  // Slot status and sticky error registers; clear discards everything in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ENTRY; i++) stat_q[i] <= '0;
      err_q <= 1'b0;
    end else if (I_Clr) begin
      for (int i = 0; i < NUM_ENTRY; i++) stat_q[i] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_ENTRY; i++) stat_q[i] <= stat_d[i];
      err_q <= err_d;
    end
  end

  // Result storage is not reset; it is only observed behind a done bit.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_ENTRY; i++) begin
      if (cmp_ok && I_Cmp_Tag == tag_t'(i)) data_q[i] <= I_Cmp_Data;
    end
  end

endmodule

// File: tb/tb_reorder_retire_buff.sv
// Directed bench: a 4-entry instance (a_*) and a 3-entry instance (b_*).
module tb_reorder_retire_buff;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // ---------------- 4-entry DUT ----------------
  logic        a_clr, a_alloc, a_ack, a_we, a_valid, a_nack, a_full, a_empty, a_err;
  logic [1:0]  a_tag, a_cmp_tag;
  logic [31:0] a_cmp_data, a_data;

  reorder_retire_buff #(.NUM_ENTRY(4), .WIDTH_DATA(32)) u_dut_a (
    .clock       (clock),
    .reset       (reset),
    .I_Clr       (a_clr),
    .I_Alloc     (a_alloc),
    .O_Alloc_Ack (a_ack),
    .O_Tag       (a_tag),
    .I_Cmp_We    (a_we),
    .I_Cmp_Tag   (a_cmp_tag),
    .I_Cmp_Data  (a_cmp_data),
    .O_Valid     (a_valid),
    .O_Data      (a_data),
    .I_Nack      (a_nack),
    .O_Full      (a_full),
    .O_Empty     (a_empty),
    .O_Err       (a_err)
  );

  // ---------------- 3-entry DUT ----------------
  logic        b_clr, b_alloc, b_ack, b_we, b_valid, b_nack, b_full, b_empty, b_err;
  logic [1:0]  b_tag, b_cmp_tag;
  logic [31:0] b_cmp_data, b_data;

  reorder_retire_buff #(.NUM_ENTRY(3), .WIDTH_DATA(32)) u_dut_b (
    .clock       (clock),
    .reset       (reset),
    .I_Clr       (b_clr),
    .I_Alloc     (b_alloc),
    .O_Alloc_Ack (b_ack),
    .O_Tag       (b_tag),
    .I_Cmp_We    (b_we),
    .I_Cmp_Tag   (b_cmp_tag),
    .I_Cmp_Data  (b_cmp_data),
    .O_Valid     (b_valid),
    .O_Data      (b_data),
    .I_Nack      (b_nack),
    .O_Full      (b_full),
    .O_Empty     (b_empty),
    .O_Err       (b_err)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pop_exp();
    logic [31:0] v;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard: expected queue empty");
      return 32'hDEAD_BEEF;
    end
    v = exp_q.pop_front();
    return v;
  endfunction

  function automatic int wrap(input int v, input int n);
    return (v == n - 1) ? 0 : v + 1;
  endfunction

  // ---------------- driver tasks ----------------
  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic drive_a(input logic alloc, input logic we, input logic [1:0] tag,
                         input logic [31:0] data, input logic nack, input logic clr);
    @(negedge clock);
    a_alloc = alloc; a_we = we; a_cmp_tag = tag; a_cmp_data = data;
    a_nack = nack; a_clr = clr;
    #1;
  endtask

  task automatic drive_b(input logic alloc, input logic we, input logic [1:0] tag,
                         input logic [31:0] data);
    @(negedge clock);
    b_alloc = alloc; b_we = we; b_cmp_tag = tag; b_cmp_data = data;
    b_nack = 1'b0; b_clr = 1'b0;
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        alloc;
    logic        we;
    logic [1:0]  tag;
    logic [31:0] data;
    logic        nack;
    logic        e_ack;
    logic [1:0]  e_tag;
    logic        e_valid;
    logic [31:0] e_data;
    logic        e_full;
    logic        e_empty;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mk(input logic alloc, input logic we, input logic [1:0] tag,
                              input logic [31:0] data, input logic nack, input logic e_ack,
                              input logic [1:0] e_tag, input logic e_valid,
                              input logic [31:0] e_data, input logic e_full,
                              input logic e_empty);
    vec_t v;
    v.alloc = alloc; v.we = we; v.tag = tag; v.data = data; v.nack = nack;
    v.e_ack = e_ack; v.e_tag = e_tag; v.e_valid = e_valid; v.e_data = e_data;
    v.e_full = e_full; v.e_empty = e_empty;
    return v;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    int m_aptr, m_hptr, m3_aptr, m3_hptr, nxt, t;
    logic [31:0] d;

    a_clr = 0; a_alloc = 0; a_we = 0; a_cmp_tag = 0; a_cmp_data = 0; a_nack = 0;
    b_clr = 0; b_alloc = 0; b_we = 0; b_cmp_tag = 0; b_cmp_data = 0; b_nack = 0;

    //           alloc we tag data    nack | ack tag valid data    full empty
    vecs[0]  = mk(0, 0, 0, 32'h0, 0,   0, 0, 0, 32'h0, 0, 1); // idle after reset
    vecs[1]  = mk(1, 0, 0, 32'h0, 0,   1, 0, 0, 32'h0, 0, 1);
    vecs[2]  = mk(1, 0, 0, 32'h0, 0,   1, 1, 0, 32'h0, 0, 0);
    vecs[3]  = mk(1, 0, 0, 32'h0, 0,   1, 2, 0, 32'h0, 0, 0);
    vecs[4]  = mk(1, 0, 0, 32'h0, 0,   1, 3, 0, 32'h0, 0, 0);
    vecs[5]  = mk(1, 0, 0, 32'h0, 0,   0, 0, 0, 32'h0, 1, 0); // 5th alloc refused
    vecs[6]  = mk(0, 1, 2, 32'hC, 0,   0, 0, 0, 32'h0, 1, 0);
    vecs[7]  = mk(0, 1, 0, 32'hA, 0,   0, 0, 0, 32'h0, 1, 0);
    vecs[8]  = mk(0, 1, 3, 32'hD, 0,   0, 0, 1, 32'hA, 1, 0); // head done, retires A
    vecs[9]  = mk(0, 1, 1, 32'hB, 0,   0, 0, 0, 32'h0, 0, 0); // new head not yet done
    vecs[10] = mk(0, 0, 0, 32'h0, 0,   0, 0, 1, 32'hB, 0, 0);
    vecs[11] = mk(0, 0, 0, 32'h0, 0,   0, 0, 1, 32'hC, 0, 0);
    vecs[12] = mk(0, 0, 0, 32'h0, 0,   0, 0, 1, 32'hD, 0, 0);
    vecs[13] = mk(0, 0, 0, 32'h0, 0,   0, 0, 0, 32'h0, 0, 1);

    // Reset state
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_empty", 32'(a_empty), 32'd1);
    chk("rst_full",  32'(a_full),  32'd0);
    chk("rst_valid", 32'(a_valid), 32'd0);
    chk("rst_tag",   32'(a_tag),   32'd0);
    chk("rst_err",   32'(a_err),   32'd0);
    chk("rst_ack",   32'(a_ack),   32'd0);
    chk("rst_b_empty", 32'(b_empty), 32'd1);

    // Tests 1-2: fill, out-of-order complete, in-order drain
    for (int i = 0; i < 14; i++) begin
      drive_a(vecs[i].alloc, vecs[i].we, vecs[i].tag, vecs[i].data, vecs[i].nack, 1'b0);
      chk($sformatf("vec%0d_ack", i),   32'(a_ack),   32'(vecs[i].e_ack));
      chk($sformatf("vec%0d_tag", i),   32'(a_tag),   32'(vecs[i].e_tag));
      chk($sformatf("vec%0d_valid", i), 32'(a_valid), 32'(vecs[i].e_valid));
      if (vecs[i].e_valid) chk($sformatf("vec%0d_data", i), a_data, vecs[i].e_data);
      chk($sformatf("vec%0d_full", i),  32'(a_full),  32'(vecs[i].e_full));
      chk($sformatf("vec%0d_empty", i), 32'(a_empty), 32'(vecs[i].e_empty));
    end
    chk("tbl_err", 32'(a_err), 32'd0);

    // Test 3: nack holds the head (pointers now 0/0)
    drive_a(1, 0, 0, 32'h0, 0, 0);
    chk("nk_ack", 32'(a_ack), 32'd1);
    chk("nk_tag", 32'(a_tag), 32'd0);
    drive_a(0, 1, 0, 32'h55, 0, 0);
    chk("nk_cmp_valid", 32'(a_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive_a(0, 0, 0, 32'h0, 1, 0);
      chk($sformatf("nk%0d_valid", i), 32'(a_valid), 32'd1);
      chk($sformatf("nk%0d_data", i),  a_data,        32'h55);
      chk($sformatf("nk%0d_empty", i), 32'(a_empty), 32'd0);
      chk($sformatf("nk%0d_tag", i),   32'(a_tag),   32'd1);
    end
    drive_a(0, 0, 0, 32'h0, 0, 0);
    chk("nk_rel_valid", 32'(a_valid), 32'd1);
    chk("nk_rel_data",  a_data,        32'h55);
    drive_a(0, 0, 0, 32'h0, 0, 0);
    chk("nk_done_empty", 32'(a_empty), 32'd1);
    chk("nk_done_valid", 32'(a_valid), 32'd0);

    // Test 4: steady state with two occupied slots
    m_aptr = 1; m_hptr = 1;
    drive_a(1, 0, 0, 32'h0, 0, 0);
    chk("ss_setup0_tag", 32'(a_tag), 32'(m_aptr));
    m_aptr = wrap(m_aptr, 4);
    drive_a(1, 1, 2'(m_hptr), 32'h200, 0, 0);
    chk("ss_setup1_tag", 32'(a_tag), 32'(m_aptr));
    exp_q.push_back(32'h200);
    m_aptr = wrap(m_aptr, 4);
    for (int i = 0; i < 10; i++) begin
      nxt = wrap(m_hptr, 4);
      d   = 32'h300 + 32'(i);
      drive_a(1, 1, 2'(nxt), d, 0, 0);
      chk($sformatf("ss%0d_ack", i),   32'(a_ack),   32'd1);
      chk($sformatf("ss%0d_tag", i),   32'(a_tag),   32'(m_aptr));
      chk($sformatf("ss%0d_valid", i), 32'(a_valid), 32'd1);
      chk($sformatf("ss%0d_data", i),  a_data,        pop_exp());
      chk($sformatf("ss%0d_full", i),  32'(a_full),  32'd0);
      chk($sformatf("ss%0d_empty", i), 32'(a_empty), 32'd0);
      exp_q.push_back(d);
      m_aptr = wrap(m_aptr, 4);
      m_hptr = nxt;
    end
    drive_a(0, 0, 0, 32'h0, 0, 0);
    chk("ss_drain0_valid", 32'(a_valid), 32'd1);
    chk("ss_drain0_data",  a_data,        pop_exp());
    m_hptr = wrap(m_hptr, 4);
    drive_a(0, 1, 2'(m_hptr), 32'h400, 0, 0);
    chk("ss_drain1_valid", 32'(a_valid), 32'd0);
    chk("ss_drain1_empty", 32'(a_empty), 32'd0);
    drive_a(0, 0, 0, 32'h0, 0, 0);
    chk("ss_drain2_valid", 32'(a_valid), 32'd1);
    chk("ss_drain2_data",  a_data,        32'h400);
    m_hptr = wrap(m_hptr, 4);
    drive_a(0, 0, 0, 32'h0, 0, 0);
    chk("ss_drain3_empty", 32'(a_empty), 32'd1);
    chk("ss_ptr_model", 32'(m_aptr), 32'(m_hptr));

    // Test 5: 3-entry instance, 7 fill/complete/drain rounds
    m3_aptr = 0; m3_hptr = 0;
    for (int r = 0; r < 7; r++) begin
      for (int k = 0; k < 3; k++) begin
        drive_b(1, 0, 0, 32'h0);
        chk($sformatf("b%0d_%0d_ack", r, k), 32'(b_ack), 32'd1);
        chk($sformatf("b%0d_%0d_tag", r, k), 32'(b_tag), 32'(m3_aptr));
        m3_aptr = wrap(m3_aptr, 3);
      end
      drive_b(1, 0, 0, 32'h0);
      chk($sformatf("b%0d_full", r),     32'(b_full),  32'd1);
      chk($sformatf("b%0d_full_ack", r), 32'(b_ack),   32'd0);
      chk($sformatf("b%0d_valid0", r),   32'(b_valid), 32'd0);
      for (int k = 0; k < 3; k++) exp_q.push_back(32'h10 * 32'(r) + 32'(k));
      t = m3_hptr;
      drive_b(0, 1, 2'(wrap(wrap(t, 3), 3)), 32'h10 * 32'(r) + 32'd2);
      chk($sformatf("b%0d_c2_valid", r), 32'(b_valid), 32'd0);
      drive_b(0, 1, 2'(t), 32'h10 * 32'(r));
      chk($sformatf("b%0d_c0_valid", r), 32'(b_valid), 32'd0);
      drive_b(0, 1, 2'(wrap(t, 3)), 32'h10 * 32'(r) + 32'd1);
      chk($sformatf("b%0d_c1_valid", r), 32'(b_valid), 32'd1);
      chk($sformatf("b%0d_r0_data", r),  b_data,        pop_exp());
      for (int k = 1; k < 3; k++) begin
        drive_b(0, 0, 0, 32'h0);
        chk($sformatf("b%0d_r%0d_valid", r, k), 32'(b_valid), 32'd1);
        chk($sformatf("b%0d_r%0d_data", r, k),  b_data,        pop_exp());
      end
      drive_b(0, 0, 0, 32'h0);
      chk($sformatf("b%0d_empty", r), 32'(b_empty), 32'd1);
      chk($sformatf("b%0d_err", r),   32'(b_err),   32'd0);
    end

    // Test 6: illegal completions, clear, async reset
    drive_a(0, 1, 2'(wrap(m_aptr, 4)), 32'h66, 0, 0);
    chk("err_pre", 32'(a_err), 32'd0);
    drive_a(0, 0, 0, 32'h0, 0, 0);
    chk("err_unalloc", 32'(a_err),   32'd1);
    chk("err_empty",   32'(a_empty), 32'd1);
    chk("err_valid",   32'(a_valid), 32'd0);
    drive_a(1, 0, 0, 32'h0, 1, 0);
    chk("err_alloc_tag", 32'(a_tag), 32'(m_aptr));
    t = m_aptr;
    drive_a(0, 1, 2'(t), 32'h77, 1, 0);
    drive_a(0, 1, 2'(t), 32'h88, 1, 0);
    chk("dup_valid", 32'(a_valid), 32'd1);
    chk("dup_data0", a_data,        32'h77);
    drive_a(0, 0, 0, 32'h0, 1, 0);
    chk("dup_data1", a_data,        32'h77);
    chk("dup_err",   32'(a_err),   32'd1);
    drive_a(0, 0, 0, 32'h0, 1, 1);
    drive_a(0, 0, 0, 32'h0, 0, 0);
    chk("clr_err",   32'(a_err),   32'd0);
    chk("clr_empty", 32'(a_empty), 32'd1);
    chk("clr_tag",   32'(a_tag),   32'd0);
    chk("clr_valid", 32'(a_valid), 32'd0);
    // completion to the slot being allocated this cycle is illegal
    drive_a(1, 1, 0, 32'h99, 0, 0);
    chk("same_ack", 32'(a_ack), 32'd1);
    drive_a(1, 0, 0, 32'h0, 0, 0);
    chk("same_err",   32'(a_err),   32'd1);
    chk("same_valid", 32'(a_valid), 32'd0);
    drive_a(0, 0, 0, 32'h0, 0, 0);
    chk("pre_rst_tag",   32'(a_tag),   32'd2);
    chk("pre_rst_empty", 32'(a_empty), 32'd0);
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_tag",   32'(a_tag),   32'd0);
    chk("arst_empty", 32'(a_empty), 32'd1);
    chk("arst_err",   32'(a_err),   32'd0);
    chk("arst_valid", 32'(a_valid), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    drive_a(0, 0, 0, 32'h0, 0, 0);
    chk("post_rst_empty", 32'(a_empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
